// File: rtl/wb_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_mem_bridge_if
// Description : Wishbone classic single-beat bus bundle for wb_mem_bridge.
//               Signal names keep the slave-side direction suffix so the
//               bridge body reads like a plain Wishbone slave.
//   wb_cyc_i  cycle valid           wb_stb_i  strobe
//   wb_we_i   1 = write             wb_sel_i  byte enables (active-high)
//   wb_adr_i  address               wb_dat_i  write data
//   wb_dat_o  read data             wb_ack_o  one-cycle acknowledge
//   wb_err_o  one-cycle error
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_mem_bridge_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [SEL_W-1:0]  wb_sel_i;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : wb_mem_bridge
// Description : Wishbone classic slave turning single-beat cycles into timed
//               SRAM-style strobe accesses for the DDR2 front-end. Requests
//               are held off until calibration is seen (with a timeout that
//               returns wb_err_o), and a master dropping cyc mid-access lets
//               the strobe window finish but suppresses the ack.
// Ports       :
//   wb_clk_i / wb_rst_i    clock, synchronous active-high reset
//   wb                     Wishbone slave bundle (wb_mem_bridge_if.slave)
//   calib_done_i           raw calibration flag (foreign clock domain)
//   init_calib_complete    calib_done_i after a 2-flop synchroniser
//   mem_a / mem_dq_o       latched address / write data
//   mem_dq_i               read data from memory
//   mem_cen/oen/wen        active-low chip / output / write enables
//   mem_sel                active-low byte mask (~latched wb_sel_i)
//   busy_o                 high whenever the bridge is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mem_bridge #(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 32,
    parameter int RD_WAIT     = 80,
    parameter int WR_WAIT     = 80,
    parameter int CAL_TIMEOUT = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    wb_mem_bridge_if.slave      wb,
    input  logic                calib_done_i,
    output logic                init_calib_complete,
    output logic [ADDR_W-1:0]   mem_a,
    output logic [DATA_W-1:0]   mem_dq_o,
    input  logic [DATA_W-1:0]   mem_dq_i,
    output logic                mem_cen,
    output logic                mem_oen,
    output logic                mem_wen,
    output logic [DATA_W/8-1:0] mem_sel,
    output logic                busy_o
);
    localparam int SEL_W = DATA_W / 8;

    localparam logic [CNT_W-1:0] c_rd_last  = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] c_wr_last  = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0] c_cal_last = CNT_W'(CAL_TIMEOUT - 1);

    generate
        if ((DATA_W % 8) != 0) begin : g_chk_data_w
            $error("wb_mem_bridge: DATA_W must be a multiple of 8");
        end
        if (RD_WAIT < 1 || WR_WAIT < 1 || CAL_TIMEOUT < 1) begin : g_chk_waits
            $error("wb_mem_bridge: RD_WAIT, WR_WAIT and CAL_TIMEOUT must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CAL_WAIT = 3'd1,
        S_READ     = 3'd2,
        S_WRITE    = 3'd3,
        S_ACK      = 3'd4,
        S_ERR      = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                abort_q, abort_d;
    logic [1:0]          sync_q;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [DATA_W-1:0]   mem_dq_q, mem_dq_d;
    logic [SEL_W-1:0]    mem_sel_q, mem_sel_d;
    logic                cen_q, cen_d;
    logic                oen_q, oen_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    // Access launch request from IDLE or CAL_WAIT, with the direction to use.
    logic                w_start;
    logic                w_start_we;
    logic                w_cal;

    assign w_cal = sync_q[1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        abort_d    = abort_q;
        mem_a_d    = mem_a_q;
        mem_dq_d   = mem_dq_q;
        mem_sel_d  = mem_sel_q;
        cen_d      = 1'b1;
        oen_d      = 1'b1;
        wen_d      = 1'b1;
        dat_d      = dat_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        w_start    = 1'b0;
        w_start_we = we_q;

        case (state_q)
            S_IDLE: begin
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    mem_a_d   = wb.wb_adr_i;
                    mem_dq_d  = wb.wb_dat_i;
                    mem_sel_d = ~wb.wb_sel_i;
                    we_d      = wb.wb_we_i;
                    cnt_d     = '0;
                    if (w_cal) begin
                        w_start    = 1'b1;
                        w_start_we = wb.wb_we_i;
                    end else begin
                        state_d = S_CAL_WAIT;
                    end
                end
            end

            S_CAL_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Priority: master abort, then calibration, then timeout, so a
                // calibration arriving on the timeout cycle still proceeds.
                if (!wb.wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (w_cal) begin
                    w_start = 1'b1;
                end else if (cnt_q == c_cal_last) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end
            end

            S_READ: begin
                if (cnt_q == c_rd_last) begin
                    // Window done; an aborted cycle gets neither ack nor data.
                    if (abort_q || !wb.wb_cyc_i) begin
                        state_d = S_IDLE;
                    end else begin
                        dat_d   = mem_dq_i;
                        ack_d   = 1'b1;
                        state_d = S_ACK;
                    end
                end else begin
                    cen_d   = 1'b0;
                    oen_d   = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    abort_d = abort_q | ~wb.wb_cyc_i;
                end
            end

            S_WRITE: begin
                if (cnt_q == c_wr_last) begin
                    if (abort_q || !wb.wb_cyc_i) begin
                        state_d = S_IDLE;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = S_ACK;
                    end
                end else begin
                    cen_d   = 1'b0;
                    wen_d   = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    abort_d = abort_q | ~wb.wb_cyc_i;
                end
            end

            S_ACK:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered, so they must be driven low in the same
        // cycle the access state is entered.
        if (w_start) begin
            cnt_d   = '0;
            abort_d = 1'b0;
            state_d = w_start_we ? S_WRITE : S_READ;
            cen_d   = 1'b0;
            oen_d   = w_start_we;
            wen_d   = ~w_start_we;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            abort_q   <= 1'b0;
            sync_q    <= 2'b00;
            mem_a_q   <= '0;
            mem_dq_q  <= '0;
            mem_sel_q <= '1;
            cen_q     <= 1'b1;
            oen_q     <= 1'b1;
            wen_q     <= 1'b1;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            abort_q   <= abort_d;
            sync_q    <= {sync_q[0], calib_done_i};
            mem_a_q   <= mem_a_d;
            mem_dq_q  <= mem_dq_d;
            mem_sel_q <= mem_sel_d;
            cen_q     <= cen_d;
            oen_q     <= oen_d;
            wen_q     <= wen_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign init_calib_complete = sync_q[1];
    assign mem_a               = mem_a_q;
    assign mem_dq_o            = mem_dq_q;
    assign mem_sel             = mem_sel_q;
    assign mem_cen             = cen_q;
    assign mem_oen             = oen_q;
    assign mem_wen             = wen_q;
    assign busy_o              = busy_q;
    assign wb.wb_dat_o         = dat_q;
    assign wb.wb_ack_o         = ack_q;
    assign wb.wb_err_o         = err_q;

endmodule
`default_nettype wire

// File: doc/wb_mem_bridge.md
Name: wb_mem_bridge

Overview:
- Parametrised Wishbone classic slave that converts single-beat bus cycles into timed accesses on the SRAM-style strobe interface of the DDR2 front-end (active-low chip/output/write enables and byte masks).
- Successor to the fixed 32-bit/80-cycle bridge. Adds configurable address/data width and separate read/write wait counts.
- New behaviour: calibration gating with a timeout error, a clean abort when the master drops cyc, and a busy indicator.
- Sits between the CPU data-bus arbiter and the Ram2Ddr controller.

Parameters:
- ADDR_W, 27, Wishbone and memory address width.
- DATA_W, 32, data width; must be a multiple of 8. SEL_W = DATA_W/8.
- RD_WAIT, 80, cycles the read strobes are held low; must be >= 1.
- WR_WAIT, 80, cycles the write strobes are held low; must be >= 1.
- CAL_TIMEOUT, 1024, cycles a request may wait for calibration before wb_err_o is raised; must be >= 1.
- CNT_W, 16, wait/timeout counter width; must hold max(RD_WAIT, WR_WAIT, CAL_TIMEOUT).

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_sel_i  in  SEL_W  byte enables, active-high.
- wb_adr_i  in  ADDR_W  address.
- wb_dat_i  in  DATA_W  write data.
- wb_dat_o  out  DATA_W  read data, registered.
- wb_ack_o  out  1  one-cycle acknowledge.
- wb_err_o  out  1  one-cycle error (calibration timeout).
- calib_done_i  in  1  raw calibration flag from the 200 MHz domain.
- init_calib_complete  out  1  calib_done_i after a 2-flop synchroniser.
- mem_a  out  ADDR_W  memory address.
- mem_dq_o  out  DATA_W  write data to memory.
- mem_dq_i  in  DATA_W  read data from memory.
- mem_cen  out  1  chip enable, active-low.
- mem_oen  out  1  output enable, active-low.
- mem_wen  out  1  write enable, active-low.
- mem_sel  out  SEL_W  byte mask, active-low; equals ~latched wb_sel_i.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (sampled on the wb_clk_i edge):
  - State goes to IDLE.
  - mem_cen, mem_oen, mem_wen = 1; mem_sel = all 1.
  - mem_a, mem_dq_o, wb_dat_o = 0.
  - wb_ack_o, wb_err_o, busy_o, init_calib_complete = 0.
  - Synchroniser flops and counters cleared.
  - Reset mid-access de-asserts all strobes on the next edge; no ack or err is issued.
- States: IDLE, CAL_WAIT, READ, WRITE, ACK, ERR. All outputs are registered.
- IDLE, with wb_cyc_i & wb_stb_i high:
  - Latch wb_adr_i into mem_a, wb_dat_i into mem_dq_o, ~wb_sel_i into mem_sel, and wb_we_i.
  - If init_calib_complete = 1: go to WRITE or READ per wb_we_i.
  - Otherwise go to CAL_WAIT with the counter cleared.
- CAL_WAIT:
  - Counter increments each cycle.
  - If wb_cyc_i drops, return to IDLE silently.
  - If init_calib_complete rises, go to READ/WRITE.
  - If the counter reaches CAL_TIMEOUT-1 without calibration, go to ERR.
  - If calibration rises in the same cycle the timeout is reached, calibration wins.
- READ:
  - mem_cen = 0, mem_oen = 0, mem_wen = 1, held for exactly RD_WAIT cycles.
  - On the last of those cycles, capture mem_dq_i into wb_dat_o.
  - Then strobes return to 1 and the state goes to ACK.
- WRITE:
  - mem_cen = 0, mem_wen = 0, mem_oen = 1, held for exactly WR_WAIT cycles.
  - Then strobes return to 1 and the state goes to ACK.
  - mem_a, mem_dq_o and mem_sel are stable for the whole strobe window.
- Abort: if wb_cyc_i drops during READ or WRITE, the strobe window still completes (the memory front-end needs the full window). The ACK state is then skipped: return to IDLE with no ack, and wb_dat_o is not updated.
- ACK: wb_ack_o = 1 for exactly one cycle, then IDLE. wb_dat_o holds its value until the next completed read.
- ERR: wb_err_o = 1 for one cycle, then IDLE. No memory strobe is ever asserted.
- Latency, measured from the IDLE sampling cycle T with calibration done:
  - Strobes are low during T+1 .. T+WAIT.
  - Ack is at T+WAIT+1.
  - IDLE is re-entered at T+WAIT+2.
  - Minimum request period is WAIT+2 cycles.
- A request still present in IDLE after an ack is treated as a new request; masters drop stb on ack.
- wb_ack_o and wb_err_o are never high in the same cycle and are never high during reset.

Test Plan:
- Reset, then calib_done_i = 1 for 3 cycles. Write adr=0x0000100, dat=0xDEADBEEF, sel=4'b1111 -> init_calib_complete high 2 cycles after calib_done_i; mem_cen and mem_wen low for exactly 80 cycles with mem_a=0x100 and mem_dq_o=0xDEADBEEF; wb_ack_o high on cycle 81 only.
- Read adr=0x100, memory model returns 0xDEADBEEF -> mem_oen low for 80 cycles; wb_dat_o=0xDEADBEEF at ack; no write strobe seen.
- Byte write with sel=4'b0101 -> mem_sel=4'b1010 for the whole window.
- calib_done_i held 0, CAL_TIMEOUT=16, read issued -> wb_err_o pulses once after 16 cycles in CAL_WAIT; no strobes; busy_o drops the next cycle.
- wb_cyc_i dropped at cycle 10 of a read -> strobes still low through cycle 80; no ack; wb_dat_o keeps its previous value.
- wb_rst_i asserted at cycle 40 of a write -> strobes return to 1 on the next edge; no ack/err; the next write completes normally with DATA_W=64, RD_WAIT=WR_WAIT=4 (ack at T+5).
